// File: rtl/sd_read_sector.sv
// SPI-mode SD single-block reader: issues CMD17 for one sector and streams the
// 512 data bytes out as 256 big-endian 16-bit words. SCK comes from a clock enable.
module sd_read_sector #(
  parameter int unsigned DIV_HALF      = 2,
  parameter int unsigned RESP_TIMEOUT  = 64,
  parameter int unsigned TOKEN_TIMEOUT = 20000
) (
  input  logic        clk_ref,
  input  logic        rst,
  input  logic        sd_init_done,
  input  logic        rd_start,
  input  logic [31:0] rd_sec_addr,
  input  logic        sd_miso,
  output logic        sd_clk,
  output logic        sd_cs,
  output logic        sd_mosi,
  output logic        rd_busy,
  output logic        rd_val_en,
  output logic [15:0] rd_val_data,
  output logic        rd_done,
  output logic        rd_err
);

  localparam int unsigned WAIT_MAX = (TOKEN_TIMEOUT > RESP_TIMEOUT) ? TOKEN_TIMEOUT : RESP_TIMEOUT;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int unsigned DIV_W    = $clog2(DIV_HALF + 1);
  localparam int unsigned CMD_W    = 48;
  localparam int unsigned BIT_W    = 12;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_PRE   = 4'd1;
  localparam logic [3:0] S_CMD   = 4'd2;
  localparam logic [3:0] S_RESP  = 4'd3;
  localparam logic [3:0] S_TOKEN = 4'd4;
  localparam logic [3:0] S_DATA  = 4'd5;
  localparam logic [3:0] S_CRC   = 4'd6;
  localparam logic [3:0] S_POST  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  logic              set_err;
  logic              err_flag;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              r1_found;
  logic [6:0]        r1_sr;
  logic [CMD_W-1:0]  cmd_sr;
  logic [14:0]       data_sr;

  logic              engine_on;
  logic              sck_tick;
  logic              sck_rise;
  logic              sck_fall;
  logic [7:0]        r1_byte;
  logic              resp_tmo;
  logic              token_tmo;

  // SCK runs only while a transaction owns the bus
  assign engine_on = (state != S_IDLE) && (state != S_DONE);
  assign sck_tick  = engine_on && (div_cnt == DIV_W'(DIV_HALF - 1));
  assign sck_rise  = sck_tick && !sd_clk;
  assign sck_fall  = sck_tick && sd_clk;
  assign r1_byte   = {r1_sr, sd_miso};
  assign resp_tmo  = (wait_cnt == WAIT_W'(RESP_TIMEOUT - 1));
  assign token_tmo = (wait_cnt == WAIT_W'(TOKEN_TIMEOUT - 1));

  always_ff @(posedge clk_ref) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Bit-level decisions are taken on SCK rising edges; POST ends on a falling edge
  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    case (state)
      S_IDLE:  if (rd_start && sd_init_done) state_nxt = S_PRE;
      S_PRE:   if (sck_rise && bit_cnt == BIT_W'(7)) state_nxt = S_CMD;
      S_CMD:   if (sck_rise && bit_cnt == BIT_W'(CMD_W - 1)) state_nxt = S_RESP;
      S_RESP: begin
        if (sck_rise) begin
          if (r1_found) begin
            if (bit_cnt == BIT_W'(6)) begin
              state_nxt = (r1_byte == 8'h00) ? S_TOKEN : S_POST;
              set_err   = (r1_byte != 8'h00);
            end
          end else if (sd_miso && resp_tmo) begin
            state_nxt = S_POST;
            set_err   = 1'b1;
          end
        end
      end
      S_TOKEN: begin
        if (sck_rise) begin
          if (!sd_miso) begin
            state_nxt = S_DATA;
          end else if (token_tmo) begin
            state_nxt = S_POST;
            set_err   = 1'b1;
          end
        end
      end
      S_DATA:  if (sck_rise && bit_cnt == BIT_W'(4095)) state_nxt = S_CRC;
      S_CRC:   if (sck_rise && bit_cnt == BIT_W'(15)) state_nxt = S_POST;
      S_POST:  if (sck_fall && bit_cnt == BIT_W'(8)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      r1_found    <= 1'b0;
      r1_sr       <= '0;
      cmd_sr      <= '0;
      data_sr     <= '0;
      err_flag    <= 1'b0;
      sd_clk      <= 1'b0;
      sd_cs       <= 1'b1;
      sd_mosi     <= 1'b1;
      rd_busy     <= 1'b0;
      rd_val_en   <= 1'b0;
      rd_val_data <= '0;
      rd_done     <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      rd_val_en <= 1'b0;
      rd_busy   <= (state_nxt != S_IDLE);
      rd_done   <= (state_nxt == S_DONE) && (state != S_DONE) && !err_flag;
      rd_err    <= (state_nxt == S_DONE) && (state != S_DONE) && err_flag;
      err_flag  <= err_flag | set_err;

      if (!engine_on) begin
        div_cnt <= '0;
        sd_clk  <= 1'b0;
      end else if (sck_tick) begin
        div_cnt <= '0;
        sd_clk  <= !sd_clk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      // Per-state bit and wait counters restart on every state change
      if (state_nxt != state) begin
        bit_cnt  <= '0;
        wait_cnt <= '0;
        r1_found <= 1'b0;
      end else begin
        case (state)
          S_PRE, S_CMD, S_DATA, S_CRC: if (sck_rise) bit_cnt <= bit_cnt + BIT_W'(1);
          S_POST: if (sck_fall) bit_cnt <= bit_cnt + BIT_W'(1);
          S_RESP: begin
            if (sck_rise) begin
              if (r1_found) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                r1_sr   <= {r1_sr[5:0], sd_miso};
              end else if (!sd_miso) begin
                r1_found <= 1'b1;
                r1_sr    <= '0;
              end else begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
              end
            end
          end
          S_TOKEN: if (sck_rise) wait_cnt <= wait_cnt + WAIT_W'(1);
          default: ;
        endcase
      end

      if (sck_fall) begin
        sd_mosi <= (state == S_CMD) ? cmd_sr[CMD_W-1] : 1'b1;
        if (state == S_CMD) cmd_sr <= {cmd_sr[CMD_W-2:0], 1'b0};
      end

      // Deassert CS on the first POST falling edge so it never moves with a rising SCK
      if (state == S_POST && sck_fall) sd_cs <= 1'b1;

      if (state == S_DATA && sck_rise) begin
        data_sr <= {data_sr[13:0], sd_miso};
        if (bit_cnt[3:0] == 4'hF) begin
          rd_val_en   <= 1'b1;
          rd_val_data <= {data_sr, sd_miso};
        end
      end

      if (state == S_IDLE && state_nxt == S_PRE) begin
        cmd_sr   <= {8'h51, rd_sec_addr, 8'hFF};
        err_flag <= 1'b0;
        sd_cs    <= 1'b0;
        sd_mosi  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_read_sector.sv
// Bench for sd_read_sector: behavioural SD card plus transaction-level expectations,
// run against a DIV_HALF=2 and a DIV_HALF=1 instance sharing one card.
module tb_sd_read_sector;

  localparam int RESP_TO = 64;
  localparam int TOK_TO  = 32;

  logic        clk_ref = 1'b0;
  logic        rst;
  logic        sd_init_done;
  logic        rd_start;
  logic [31:0] rd_sec_addr;
  logic        sd_miso = 1'b1;
  logic        sel;

  logic        clk0, cs0, mosi0, busy0, ven0, done0, err0;
  logic        clk1, cs1, mosi1, busy1, ven1, done1, err1;
  logic [15:0] vdat0, vdat1;

  wire         start0 = rd_start & ~sel;
  wire         start1 = rd_start & sel;
  wire         sck_c  = clk0 | clk1;
  wire         cs_c   = cs0 & cs1;
  wire         mosi_c = mosi0 & mosi1;
  wire         busy_c = sel ? busy1 : busy0;
  wire         ven_c  = sel ? ven1 : ven0;
  wire         done_c = sel ? done1 : done0;
  wire         err_c  = sel ? err1 : err0;
  wire  [15:0] vdat_c = sel ? vdat1 : vdat0;

  always #5 clk_ref = ~clk_ref;

  sd_read_sector #(.DIV_HALF(2), .RESP_TIMEOUT(RESP_TO), .TOKEN_TIMEOUT(TOK_TO)) dut (
    .clk_ref(clk_ref), .rst(rst), .sd_init_done(sd_init_done), .rd_start(start0),
    .rd_sec_addr(rd_sec_addr), .sd_miso(sd_miso), .sd_clk(clk0), .sd_cs(cs0),
    .sd_mosi(mosi0), .rd_busy(busy0), .rd_val_en(ven0), .rd_val_data(vdat0),
    .rd_done(done0), .rd_err(err0));

  sd_read_sector #(.DIV_HALF(1), .RESP_TIMEOUT(RESP_TO), .TOKEN_TIMEOUT(TOK_TO)) dut_fast (
    .clk_ref(clk_ref), .rst(rst), .sd_init_done(sd_init_done), .rd_start(start1),
    .rd_sec_addr(rd_sec_addr), .sd_miso(sd_miso), .sd_clk(clk1), .sd_cs(cs1),
    .sd_mosi(mosi1), .rd_busy(busy1), .rd_val_en(ven1), .rd_val_data(vdat1),
    .rd_done(done1), .rd_err(err1));

  int          n_checks;
  int          n_errors;
  int          cyc;
  logic [7:0]  sector [0:511];
  logic        miso_bits [0:8191];
  int          miso_len;
  int          bidx;
  logic [15:0] got_words [$];
  int          strobe_cyc [$];
  logic        mosi_bits [$];
  int          n_done, n_err, n_both, n_low, n_high, n_cs_fall;
  logic        prev_cs = 1'b1;
  logic        prev_sck = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk_ref) cyc <= cyc + 1;

  // Card model and bus monitor: everything sampled mid-cycle on the falling clk_ref edge
  always @(negedge clk_ref) begin
    if (ven_c) begin
      got_words.push_back(vdat_c);
      strobe_cyc.push_back(cyc);
    end
    if (done_c) n_done++;
    if (err_c) n_err++;
    if (done_c && err_c) n_both++;
    if (prev_cs && !cs_c) begin
      n_cs_fall++;
      bidx    = 0;
      sd_miso = miso_bits[0];
    end else if (!prev_cs && cs_c) begin
      sd_miso = 1'b1;
    end else if (!cs_c && prev_sck && !sck_c) begin
      bidx++;
      sd_miso = (bidx < miso_len) ? miso_bits[bidx] : 1'b1;
    end
    if (!prev_sck && sck_c) begin
      if (!cs_c) begin
        mosi_bits.push_back(mosi_c);
        n_low++;
      end else begin
        n_high++;
      end
    end
    prev_cs  = cs_c;
    prev_sck = sck_c;
  end

  function automatic void push_bit(input logic b);
    miso_bits[miso_len] = b;
    miso_len++;
  endfunction

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_sck"},  32'(sck_c),  32'd0);
    check({pfx, "_cs"},   32'(cs_c),   32'd1);
    check({pfx, "_mosi"}, 32'(mosi_c), 32'd1);
    check({pfx, "_busy"}, 32'(busy_c), 32'd0);
    check({pfx, "_ven"},  32'(ven_c),  32'd0);
    check({pfx, "_data"}, 32'(vdat_c), 32'd0);
    check({pfx, "_done"}, 32'(done_c), 32'd0);
    check({pfx, "_err"},  32'(err_c),  32'd0);
  endtask

  task automatic run_read(input logic s, input logic [31:0] addr, input int r1_delay,
                          input logic [7:0] r1_val, input int tok_delay, input logic rand_data,
                          input int poke_word, input int rst_word);
    logic        exp_ok;
    int          exp_low;
    int          div;
    logic        fin, aborted, poked;
    int          bad_words, bad_gaps;
    logic [55:0] cmd_got;
    logic [15:0] exp_w;
    logic [7:0]  tok;

    for (int i = 0; i < 512; i++) sector[i] = rand_data ? 8'($urandom) : 8'(i);
    div = s ? 1 : 2;

    // Transaction-level outcome from the protocol rules
    exp_ok = (r1_delay < RESP_TO) && (r1_val == 8'h00) && (tok_delay + 8 <= TOK_TO);
    if (r1_delay >= RESP_TO)        exp_low = 56 + RESP_TO;
    else if (r1_val != 8'h00)       exp_low = 56 + r1_delay + 8;
    else if (tok_delay + 8 > TOK_TO) exp_low = 56 + r1_delay + 8 + TOK_TO;
    else                            exp_low = 56 + r1_delay + 8 + tok_delay + 8 + 4096 + 16;

    miso_len = 0;
    tok = 8'hFE;
    for (int i = 0; i < 56 + r1_delay; i++) push_bit(1'b1);
    for (int i = 7; i >= 0; i--) push_bit(r1_val[i]);
    for (int i = 0; i < tok_delay; i++) push_bit(1'b1);
    for (int i = 7; i >= 0; i--) push_bit(tok[i]);
    for (int b = 0; b < 512; b++)
      for (int i = 7; i >= 0; i--) push_bit(sector[b][i]);
    for (int i = 0; i < 16; i++) push_bit(1'($urandom));

    got_words.delete(); strobe_cyc.delete(); mosi_bits.delete();
    n_done = 0; n_err = 0; n_both = 0; n_low = 0; n_high = 0;
    sel = s; rd_sec_addr = addr; sd_init_done = 1'b1;
    check("pre_busy", 32'(busy_c), 32'd0);
    rd_start = 1'b1;
    @(negedge clk_ref); #1;
    rd_start = 1'b0;
    check("accept_busy", 32'(busy_c), 32'd1);
    check("accept_cs", 32'(cs_c), 32'd0);

    fin = 1'b0; aborted = 1'b0; poked = 1'b0;
    for (int t = 0; t < 40000 && !fin; t++) begin
      @(negedge clk_ref); #1;
      rd_start = 1'b0;
      if (poke_word >= 0 && !poked && got_words.size() == poke_word) begin
        rd_start = 1'b1;
        poked    = 1'b1;
      end
      if (rst_word >= 0 && got_words.size() == rst_word) begin
        rst = 1'b1;
        @(negedge clk_ref); #1;
        rst = 1'b0;
        check_idle_outputs("abort");
        aborted = 1'b1;
        fin     = 1'b1;
      end else if (n_done + n_err > 0) begin
        check("busy_at_done", 32'(busy_c), 32'd1);
        @(negedge clk_ref); #1;
        check("busy_after_done", 32'(busy_c), 32'd0);
        fin = 1'b1;
      end
    end
    rd_start = 1'b0;
    check("finished", 32'(fin), 32'd1);

    if (aborted) begin
      repeat (20) @(negedge clk_ref);
      #1;
      check("abort_no_pulse", 32'(n_done + n_err), 32'd0);
      check("abort_idle", 32'(busy_c), 32'd0);
      return;
    end

    check("done_cnt", 32'(n_done), 32'(exp_ok));
    check("err_cnt", 32'(n_err), 32'(!exp_ok));
    check("done_err_overlap", 32'(n_both), 32'd0);
    check("strobes", 32'(got_words.size()), exp_ok ? 32'd256 : 32'd0);

    bad_words = 0;
    for (int i = 0; i < got_words.size() && i < 256; i++) begin
      exp_w = {sector[2*i], sector[2*i+1]};
      if (got_words[i] !== exp_w) bad_words++;
    end
    check("word_mismatches", 32'(bad_words), 32'd0);
    if (got_words.size() > 0) check("first_word", 32'(got_words[0]), 32'({sector[0], sector[1]}));

    bad_gaps = 0;
    for (int i = 1; i < strobe_cyc.size(); i++)
      if (strobe_cyc[i] - strobe_cyc[i-1] != 32 * div) bad_gaps++;
    check("strobe_gap", 32'(bad_gaps), 32'd0);

    cmd_got = '0;
    for (int i = 0; i < 56 && i < mosi_bits.size(); i++) cmd_got = {cmd_got[54:0], mosi_bits[i]};
    check("mosi_pre_cmd", 32'(cmd_got[55:32]), 32'({8'hFF, 8'h51, addr[31:24]}));
    check("mosi_addr_crc", cmd_got[31:0], {addr[23:0], 8'hFF});
    check("sck_cs_low", 32'(n_low), 32'(exp_low));
    check("sck_cs_high", 32'(n_high), 32'd8);
  endtask

  initial begin
    rst = 1'b1; sd_init_done = 1'b0; rd_start = 1'b0; rd_sec_addr = '0; sel = 1'b0;
    repeat (3) @(negedge clk_ref);
    #1;
    rst = 1'b0;
    check_idle_outputs("reset0");
    sel = 1'b1;
    check_idle_outputs("reset1");
    sel = 1'b0;

    // Request without initialisation must leave the bus alone
    n_cs_fall = 0;
    rd_start = 1'b1;
    @(negedge clk_ref); #1;
    rd_start = 1'b0;
    repeat (20) @(negedge clk_ref);
    #1;
    check("gate_busy", 32'(busy_c), 32'd0);
    check("gate_cs_fall", 32'(n_cs_fall), 32'd0);

    run_read(1'b0, 32'h0000_1234, 2, 8'h00, 2, 1'b0, 50, -1);
    run_read(1'b0, 32'h0BAD_0001, 3, 8'h05, 0, 1'b1, -1, -1);
    run_read(1'b0, 32'h0000_0777, 1, 8'h00, 40, 1'b1, -1, -1);
    run_read(1'b0, 32'h1357_9BDF, 70, 8'h00, 0, 1'b1, -1, -1);
    run_read(1'b1, 32'hCAFE_0100, 2, 8'h00, 2, 1'b0, -1, 100);
    run_read(1'b1, 32'h0000_1234, 2, 8'h00, 2, 1'b0, -1, -1);

    for (int k = 0; k < 4; k++) begin
      logic [7:0] r1v;
      int         r1d;
      r1v = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 127));
      r1d = ($urandom_range(0, 7) == 0) ? 70 : int'($urandom_range(0, 20));
      run_read(1'b1, $urandom, r1d, r1v, int'($urandom_range(0, 30)), 1'b1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
